// File: rtl/alu_cmd_sequencer.sv
// Command FIFO and result register wrapped around a combinational 8-bit ALU.
// Adds divide-by-zero and illegal-opcode flags to each captured result.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_opcode,
  input  logic [7:0]    cmd_a,
  input  logic [7:0]    cmd_b,
  output logic [3:0]    alu_opcode,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  input  logic [7:0]    alu_y,
  input  logic          alu_zero,
  input  logic          alu_overflow,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [7:0]    res_y,
  output logic [3:0]    res_opcode,
  output logic          res_zero,
  output logic          res_overflow,
  output logic          res_dbz,
  output logic          res_illegal,
  output logic [CW-1:0] cmd_level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]    r_opMem [DEPTH];
  logic [7:0]    r_aMem  [DEPTH];
  logic [7:0]    r_bMem  [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_level;

  logic          r_resValid;
  logic [7:0]    r_resY;
  logic [3:0]    r_resOpcode;
  logic          r_resZero;
  logic          r_resOverflow;
  logic          r_resDbz;
  logic          r_resIllegal;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_issue;
  logic w_dbz;
  logic w_illegal;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == CW'(DEPTH));
  assign w_push  = cmd_valid && !w_full;
  assign w_issue = !w_empty && (!r_resValid || res_ready);

  // Head of the queue feeds the ALU directly; an empty queue presents all zeros.
  assign alu_opcode = w_empty ? 4'd0 : r_opMem[r_rdPtr];
  assign alu_a      = w_empty ? 8'd0 : r_aMem[r_rdPtr];
  assign alu_b      = w_empty ? 8'd0 : r_bMem[r_rdPtr];

  assign w_dbz     = (alu_opcode == 4'b0011) && (alu_b == 8'd0);
  assign w_illegal = (alu_opcode > 4'b1001);

  // Storage needs no reset: an empty queue masks whatever it holds.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_opMem[r_wrPtr] <= cmd_opcode;
      r_aMem[r_wrPtr]  <= cmd_a;
      r_bMem[r_wrPtr]  <= cmd_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push)  r_wrPtr <= r_wrPtr + AW'(1);
      if (w_issue) r_rdPtr <= r_rdPtr + AW'(1);
      if (w_push && !w_issue)      r_level <= r_level + CW'(1);
      else if (!w_push && w_issue) r_level <= r_level - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resValid    <= 1'b0;
      r_resY        <= 8'd0;
      r_resOpcode   <= 4'd0;
      r_resZero     <= 1'b0;
      r_resOverflow <= 1'b0;
      r_resDbz      <= 1'b0;
      r_resIllegal  <= 1'b0;
    end else if (w_issue) begin
      r_resValid    <= 1'b1;
      r_resY        <= w_dbz ? 8'hFF : alu_y;
      r_resZero     <= w_dbz ? 1'b0 : alu_zero;
      r_resOpcode   <= alu_opcode;
      r_resOverflow <= alu_overflow;
      r_resDbz      <= w_dbz;
      r_resIllegal  <= w_illegal;
    end else if (r_resValid && res_ready) begin
      r_resValid <= 1'b0;
    end
  end

  assign cmd_ready    = !w_full;
  assign cmd_level    = r_level;
  assign res_valid    = r_resValid;
  assign res_y        = r_resY;
  assign res_opcode   = r_resOpcode;
  assign res_zero     = r_resZero;
  assign res_overflow = r_resOverflow;
  assign res_dbz      = r_resDbz;
  assign res_illegal  = r_resIllegal;

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Sits directly upstream of the combinational 8-bit ALU (opcode/a/b in; y/zero/overflow out).
- Buffers incoming ALU commands in a small FIFO and presents the head command to the ALU.
- Captures the ALU's combinational result into an output register with a valid/ready handshake.
- Adds divide-by-zero and illegal-opcode detection, which the ALU does not provide.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, 2 to 16.
- CW, 3, width of cmd_level; must satisfy 2^CW > DEPTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  upstream command valid.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_opcode  input  4  ALU opcode: 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 AND, 0101 OR, 0110 XOR, 0111 NOT, 1000 SHL, 1001 SHR.
- cmd_a  input  8  operand a.
- cmd_b  input  8  operand b.
- alu_opcode  output  4  to ALU; FIFO head opcode.
- alu_a  output  8  to ALU; FIFO head operand a.
- alu_b  output  8  to ALU; FIFO head operand b.
- alu_y  input  8  from ALU, combinational result.
- alu_zero  input  1  from ALU.
- alu_overflow  input  1  from ALU.
- res_valid  output  1  result register holds an unconsumed result.
- res_ready  input  1  downstream accepts result.
- res_y  output  8  captured result.
- res_opcode  output  4  opcode of the captured result.
- res_zero  output  1  captured zero flag.
- res_overflow  output  1  captured overflow flag.
- res_dbz  output  1  DIV with b == 0.
- res_illegal  output  1  opcode 1010..1111.
- cmd_level  output  CW  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (rst high at an edge):
  - FIFO emptied; cmd_level = 0; res_valid = 0.
  - res_y, res_opcode, res_zero, res_overflow, res_dbz, res_illegal all 0.
  - cmd_ready = 1 from the first cycle after reset.
  - Reset mid-operation discards all queued commands and any pending result; no partial state survives.
- FIFO:
  - Circular buffer, read/write pointers wrap modulo DEPTH.
  - cmd_ready = (cmd_level != DEPTH).
  - No bypass: when full, cmd_ready stays low even if a pop occurs in the same cycle.
  - push = cmd_valid && cmd_ready.
- ALU drive:
  - alu_opcode/alu_a/alu_b = FIFO head, combinational from storage.
  - When the FIFO is empty, all three are driven 0.
- Issue:
  - issue = (cmd_level != 0) && (!res_valid || res_ready).
  - On an issue edge: head popped; result register loaded.
  - Loaded values: res_y = alu_y, res_zero = alu_zero, res_overflow = alu_overflow, res_opcode = head opcode.
  - res_dbz = (opcode == 0011 && b == 0). When set, res_y is forced to 8'hFF and res_zero to 0.
  - res_illegal = (opcode > 1001). res_y and res_zero are taken from the ALU unchanged.
  - res_valid becomes 1.
- Drain:
  - When res_valid && res_ready && !issue, res_valid becomes 0 and the data outputs hold their last values.
- Simultaneous push and pop: cmd_level unchanged; both pointers advance.
- Latency: a command accepted at edge N appears on res_* with res_valid = 1 after edge N+1, provided the result slot is free.
- Throughput: one result per cycle while res_ready is held high and commands are supplied.
- Backpressure: res_valid && !res_ready holds all res_* outputs and res_valid stable, and stops issue.
- Ordering: results leave in strict command order.
- Result data are stable whenever res_valid is 1 and not handshaken.

Test Plan:
- Reset, then push ADD a=8'h70 b=8'h20 with res_ready=1 -> after 2 edges: res_valid=1, res_y=8'h90, res_overflow=1, res_zero=0, res_opcode=0000.
- Push DIV a=8'h10 b=8'h00 -> res_dbz=1, res_y=8'hFF, res_zero=0; then DIV a=8'h10 b=8'h04 -> res_y=8'h04, res_dbz=0.
- Hold res_ready=0 and push 5 commands -> first result held stable; cmd_level reaches 4 with cmd_ready=0 (one command in the result register, four in the FIFO). Then raise res_ready -> results drain in order, one per cycle.
- Full FIFO with res_ready=1 and cmd_valid=1 -> cmd_ready=0 for that cycle (no bypass); cmd_level falls to 3, then push/pop balance.
- Push opcode 1100 a=8'h05 b=8'h03 -> res_illegal=1, res_y=8'h00, res_zero=1.
- Assert rst with 3 commands queued and res_valid=1 -> next cycle res_valid=0, cmd_level=0, cmd_ready=1, alu_* all 0.
